lzd_norm_arbiter: RTL

- Shares one 48-bit leading-zero detector and normalizing left shifter between two requesters in the noise generator: requester 0 is the log path and requester 1 is the sqrt path.
- Round-robin arbiter in front of a 2-stage registered pipeline.
- Results are routed back to the issuing requester through per-requester valid/ready handshakes with full backpressure.

---
 rtl/lzd_norm_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/lzd_norm_arbiter.sv
// Shared leading-zero detector and normalizing left shifter for the noise
// generator. Requester 0 is the log path and requester 1 is the sqrt path.
// A round-robin arbiter feeds a two-stage registered pipeline. Results are
// routed back to the issuing requester through its own valid/ready pair,
// with full backpressure.
module lzd_norm_arbiter #(
   parameter int WIDTH = 48,
   parameter int CW    = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid0,
   output logic             in_ready0,
   input  logic [WIDTH-1:0] in_data0,
   input  logic             in_valid1,
   output logic             in_ready1,
   input  logic [WIDTH-1:0] in_data1,
   output logic             out_valid0,
   input  logic             out_ready0,
   output logic             out_valid1,
   input  logic             out_ready1,
   output logic [WIDTH-1:0] out_mant,
   output logic [CW-1:0]    out_lzc,
   output logic             out_zero,
   output logic             busy
);

   // Stage 1 holds the raw operand and the tag of the requester that issued it.
   logic             s1_valid_r;
   logic             s1_tag_r;
   logic [WIDTH-1:0] s1_data_r;

   // Stage 2 holds the normalized result and the tag used to route it back.
   logic             s2_valid_r;
   logic             s2_tag_r;
   logic [WIDTH-1:0] s2_mant_r;
   logic [CW-1:0]    s2_lzc_r;
   logic             s2_zero_r;

   // Requester granted most recently. It loses the next tie.
   logic             last_grant_r;

   logic             adv1_s;
   logic             adv2_s;
   logic             grant0_s;
   logic             grant1_s;
   logic             xfer0_s;
   logic             xfer1_s;
   logic [CW-1:0]    lzc_s;
   logic [WIDTH-1:0] mant_s;
   logic             zero_s;

   // Leading-zero count from the MSB.
   // The scan runs upward, so the highest set bit determines the count.
   // An all-zero operand returns 0.
   function automatic logic [CW-1:0] lead_zeros(input logic [WIDTH-1:0] d);
      logic [CW-1:0] n;
      n = {CW{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
         n = d[i] ? CW'(WIDTH - 1 - i) : n;
      end
      return n;
   endfunction

   // Stage-advance conditions.
   // Stage 2 frees up when its owner consumes the result.
   // Stage 1 frees up when stage 2 can take its entry.
   always_comb begin
      adv2_s = 1'b1;
      adv1_s = 1'b1;
      if (s2_valid_r) begin
         adv2_s = s2_tag_r ? out_ready1 : out_ready0;
      end else begin
         adv2_s = 1'b1;
      end
      if (s1_valid_r) begin
         adv1_s = adv2_s;
      end else begin
         adv1_s = 1'b1;
      end
   end

   // Round-robin grant. A lone requester always wins.
   // On a tie, the requester that was not granted last wins.
   always_comb begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
      case ({in_valid1, in_valid0})
         2'b01: grant0_s = 1'b1;
         2'b10: grant1_s = 1'b1;
         2'b11: begin
            if (last_grant_r) begin
               grant0_s = 1'b1;
            end else begin
               grant1_s = 1'b1;
            end
         end
         default: begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
         end
      endcase
   end

   // Ready is held low while reset is asserted, so no operand is taken mid-reset.
   assign in_ready0 = rst_n & adv1_s & grant0_s;
   assign in_ready1 = rst_n & adv1_s & grant1_s;
   assign xfer0_s   = in_valid0 & in_ready0;
   assign xfer1_s   = in_valid1 & in_ready1;

   // Normalization of the stage-1 operand. A zero operand yields lzc 0 and mant 0.
   always_comb begin
      lzc_s  = lead_zeros(s1_data_r);
      mant_s = s1_data_r << lzc_s;
      zero_s = (s1_data_r == {WIDTH{1'b0}});
   end

   // Stage 1: capture the granted operand whenever the stage is free to advance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_r <= 1'b0;
         s1_tag_r   <= 1'b0;
         s1_data_r  <= {WIDTH{1'b0}};
      end else if (adv1_s) begin
         s1_valid_r <= xfer0_s | xfer1_s;
         if (xfer0_s) begin
            s1_tag_r  <= 1'b0;
            s1_data_r <= in_data0;
         end else if (xfer1_s) begin
            s1_tag_r  <= 1'b1;
            s1_data_r <= in_data1;
         end
      end
   end

   // Arbiter history. It changes only on an actual transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_r <= 1'b1;
      end else if (xfer0_s) begin
         last_grant_r <= 1'b0;
      end else if (xfer1_s) begin
         last_grant_r <= 1'b1;
      end
   end

   // Stage 2: take the normalized result.
   // It empties when the held entry is consumed and nothing follows it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid_r <= 1'b0;
         s2_tag_r   <= 1'b0;
         s2_mant_r  <= {WIDTH{1'b0}};
         s2_lzc_r   <= {CW{1'b0}};
         s2_zero_r  <= 1'b0;
      end else if (adv2_s) begin
         s2_valid_r <= s1_valid_r;
         if (s1_valid_r) begin
            s2_tag_r  <= s1_tag_r;
            s2_mant_r <= mant_s;
            s2_lzc_r  <= lzc_s;
            s2_zero_r <= zero_s;
         end
      end
   end

   assign out_valid0 = s2_valid_r & ~s2_tag_r;
   assign out_valid1 = s2_valid_r & s2_tag_r;
   assign out_mant   = s2_mant_r;
   assign out_lzc    = s2_lzc_r;
   assign out_zero   = s2_zero_r;
   assign busy       = s1_valid_r | s2_valid_r;

endmodule
